// File: rtl/avr_pmem_if.sv
// avr_pmem_if -- fetch and loader signal bundle for avr_pmem.
//   prog_addr  : word address from the fetch unit
//   prog_data  : registered instruction word back to the fetch unit
//   ld_byte    : loader byte stream data
//   ld_valid   : ld_byte valid this cycle
//   ld_ready   : program memory accepts ld_byte this cycle
//   ld_busy    : a load frame is in progress
//   hold_cpu   : hold request to the fetch unit (same as ld_busy)
//   ld_done    : one-cycle pulse at frame end
//   ld_err     : sticky checksum-error flag
// Modports: master (fetch unit / loader side), slave (program memory side).
interface avr_pmem_if;
    logic [15:0] prog_addr;
    logic [15:0] prog_data;
    logic [7:0]  ld_byte;
    logic        ld_valid;
    logic        ld_ready;
    logic        ld_busy;
    logic        hold_cpu;
    logic        ld_done;
    logic        ld_err;

    modport master (
        output prog_addr, ld_byte, ld_valid,
        input  prog_data, ld_ready, ld_busy, hold_cpu, ld_done, ld_err
    );

    modport slave (
        input  prog_addr, ld_byte, ld_valid,
        output prog_data, ld_ready, ld_busy, hold_cpu, ld_done, ld_err
    );
endinterface

// File: rtl/avr_pmem.sv
// avr_pmem -- AVR program memory with a byte-stream loader.
// The fetch port reads one 16-bit word per cycle (registered). The loader
// accepts frames: A5, ADDR_LO, ADDR_HI, COUNT (0 = 256), COUNT words sent
// low byte first, then an optional CHK byte. Each word is written in a
// one-cycle WR state during which ld_ready is low.
// Ports:
//   CLK  : clock, rising edge
//   RST  : synchronous, active-high reset (memory contents are kept)
//   bus  : avr_pmem_if.slave (fetch port and loader byte stream)
// Parameter:
//   ADDR_W : word-address width, memory holds 2^ADDR_W words
// Build option:
//   AVR_PMEM_CHKSUM_EN defined   -> frame ends with CHK byte; the 8-bit sum of
//                                   all bytes after the header must be 0,
//                                   otherwise ld_err is set (sticky until the
//                                   next accepted header)
//   AVR_PMEM_CHKSUM_EN undefined -> no CHK byte, final WR ends the frame,
//                                   ld_err tied to 0
//
// state | meaning
// IDLE  | waiting for 8'hA5 header, other bytes dropped
// ADL   | expecting address low byte
// ADH   | expecting address high byte
// CNT   | expecting word count
// DLO   | expecting data low byte
// DHI   | expecting data high byte
// WR    | writing {hi,lo}, loader stalled for this cycle
// CHK   | expecting checksum byte
module avr_pmem #(
    parameter int ADDR_W = 10
) (
    input  logic       CLK,
    input  logic       RST,
    avr_pmem_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {IDLE, ADL, ADH, CNT, DLO, DHI, WR, CHK} state_t;

    state_t      state, state_nx;
    logic [15:0] addr_q;
    logic [8:0]  cnt_q;
    logic [7:0]  lo_q, hi_q;
    logic        done_q;
    logic [15:0] prog_data_q;
    logic [15:0] mem [DEPTH];

    logic ready, busy, wr_en, accept, last_word, addr_hi_nz;

    assign accept     = bus.ld_valid && ready;
    assign last_word  = (cnt_q == 9'd1);
    assign addr_hi_nz = ((bus.prog_addr >> ADDR_W) != 16'd0);

    // State register
    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept && bus.ld_byte == 8'hA5) state_nx = ADL;
            ADL:  if (accept) state_nx = ADH;
            ADH:  if (accept) state_nx = CNT;
            CNT:  if (accept) state_nx = DLO;
            DLO:  if (accept) state_nx = DHI;
            DHI:  if (accept) state_nx = WR;
`ifdef AVR_PMEM_CHKSUM_EN
            WR:   state_nx = last_word ? CHK : DLO;
`else
            WR:   state_nx = last_word ? IDLE : DLO;
`endif
            CHK:  if (accept) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs; RST masks everything so the loader looks quiet during reset
    // even before the state register has been cleared.
    always_comb begin
        ready = 1'b0;
        busy  = 1'b0;
        wr_en = 1'b0;
        if (!RST) begin
            ready = (state != WR);
            busy  = (state != IDLE);
            wr_en = (state == WR);
        end
    end

    // Loader datapath
    always_ff @(posedge CLK) begin
        if (RST) begin
            addr_q <= 16'd0;
            cnt_q  <= 9'd0;
            lo_q   <= 8'd0;
            hi_q   <= 8'd0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ADL: if (accept) addr_q[7:0]  <= bus.ld_byte;
                ADH: if (accept) addr_q[15:8] <= bus.ld_byte;
                CNT: if (accept) cnt_q <= (bus.ld_byte == 8'd0) ? 9'd256 : {1'b0, bus.ld_byte};
                DLO: if (accept) lo_q <= bus.ld_byte;
                DHI: if (accept) hi_q <= bus.ld_byte;
                WR: begin
                    // Only the low ADDR_W bits index memory, so a plain
                    // increment wraps the load address as required.
                    addr_q <= addr_q + 16'd1;
                    cnt_q  <= cnt_q - 9'd1;
`ifndef AVR_PMEM_CHKSUM_EN
                    if (last_word) done_q <= 1'b1;
`endif
                end
                CHK: if (accept) done_q <= 1'b1;
                default: ;
            endcase
        end
    end

`ifdef AVR_PMEM_CHKSUM_EN
    logic [7:0] sum_q;
    logic [7:0] sum_nx;
    logic       err_q;

    assign sum_nx = sum_q + bus.ld_byte;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sum_q <= 8'd0;
            err_q <= 1'b0;
        end else if (accept && state == IDLE) begin
            if (bus.ld_byte == 8'hA5) begin
                sum_q <= 8'd0;
                err_q <= 1'b0;
            end
        end else if (accept) begin
            sum_q <= sum_nx;
            if (state == CHK && sum_nx != 8'd0) err_q <= 1'b1;
        end
    end

    assign bus.ld_err = err_q;
`else
    assign bus.ld_err = 1'b0;
`endif

    // Memory write; no reset so contents survive RST.
    always_ff @(posedge CLK) begin
        if (wr_en) mem[addr_q[ADDR_W-1:0]] <= {hi_q, lo_q};
    end

    // Fetch read; a same-cycle write to the same word returns old data.
    always_ff @(posedge CLK) begin
        if (RST)                    prog_data_q <= 16'h0000;
        else if (busy || addr_hi_nz) prog_data_q <= 16'h0000;
        else                        prog_data_q <= mem[bus.prog_addr[ADDR_W-1:0]];
    end

    assign bus.prog_data = prog_data_q;
    assign bus.ld_ready  = ready;
    assign bus.ld_busy   = busy;
    assign bus.hold_cpu  = busy;
    assign bus.ld_done   = done_q;
endmodule

// File: tb/tb_avr_pmem.sv
// tb_avr_pmem -- directed bench for avr_pmem (ADDR_W = 10).
// Honours AVR_PMEM_CHKSUM_EN: when defined, frames carry a CHK byte and the
// error flag is exercised; otherwise frames end after the last word.
module tb_avr_pmem;
    logic CLK;
    logic RST;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_stall  = 0;
    int   n_done   = 0;
    int   s0, d0;
    logic [15:0] fw [256];

    avr_pmem_if bus ();

    avr_pmem #(.ADDR_W(10)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (!RST && bus.ld_ready === 1'b0) n_stall++;
        if (bus.ld_done === 1'b1) n_done++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the byte transferred.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        n = 0;
        while (bus.ld_ready !== 1'b1 && n < 20) begin
            @(posedge CLK); #1;
            n++;
        end
        check("ld_ready_wait", bus.ld_ready, 16'd1);
        bus.ld_valid = 1'b1;
        bus.ld_byte  = b;
        @(posedge CLK); #1;
        bus.ld_valid = 1'b0;
        bus.ld_byte  = 8'h00;
        repeat (gap) begin @(posedge CLK); #1; end
    endtask

    task automatic send_frame(input logic [15:0] a, input int n, input int gap, input bit bad);
        logic [7:0] sum, c, chk;
        c   = n[7:0];
        sum = a[7:0] + a[15:8] + c;
        send_byte(8'hA5, gap);
        send_byte(a[7:0], gap);
        send_byte(a[15:8], gap);
        send_byte(c, gap);
        for (int i = 0; i < n; i++) begin
            send_byte(fw[i][7:0], gap);
            send_byte(fw[i][15:8], gap);
            sum = sum + fw[i][7:0] + fw[i][15:8];
        end
        chk = bad ? 8'h00 : 8'h00 - sum;
`ifdef AVR_PMEM_CHKSUM_EN
        send_byte(chk, gap);
`endif
        repeat (3) begin @(posedge CLK); #1; end
    endtask

    task automatic read_chk(input string tag, input logic [15:0] a, input logic [15:0] exp);
        bus.prog_addr = a;
        @(posedge CLK); #1;
        check(tag, bus.prog_data, exp);
    endtask

    initial begin
        RST          = 1'b1;
        bus.ld_valid = 1'b0;
        bus.ld_byte  = 8'h00;
        bus.prog_addr = 16'h0000;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_ready", bus.ld_ready, 16'd0);
        check("rst_busy", bus.ld_busy, 16'd0);
        check("rst_hold", bus.hold_cpu, 16'd0);
        check("rst_done", bus.ld_done, 16'd0);
        check("rst_err", bus.ld_err, 16'd0);
        check("rst_pdata", bus.prog_data, 16'h0000);
        RST = 1'b0;
        #1;
        check("idle_ready", bus.ld_ready, 16'd1);

        // Good load of two words at 0x010 (good CHK for these bytes is 8'hDA)
        fw[0] = 16'h1234; fw[1] = 16'h5678;
        d0 = n_done; s0 = n_stall;
        send_frame(16'h0010, 2, 0, 1'b0);
        check("good_done_cnt", 16'(n_done - d0), 16'd1);
        check("good_stall_cnt", 16'(n_stall - s0), 16'd2);
        check("good_err", bus.ld_err, 16'd0);
        check("good_busy", bus.ld_busy, 16'd0);
        read_chk("rd_010", 16'h0010, 16'h1234);
        read_chk("rd_011", 16'h0011, 16'h5678);

        // Busy read: data valid at 0x011, but a frame is in progress
        bus.prog_addr = 16'h0011;
        send_byte(8'hA5, 0);
        send_byte(8'h40, 0);
        check("busy_pdata", bus.prog_data, 16'h0000);
        check("busy_hold", bus.hold_cpu, 16'd1);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'hEF, 0);
        send_byte(8'hBE, 0);
`ifdef AVR_PMEM_CHKSUM_EN
        send_byte(8'h12, 0);
`endif
        repeat (3) begin @(posedge CLK); #1; end
        check("busy_frame_err", bus.ld_err, 16'd0);
        read_chk("rd_040", 16'h0040, 16'hBEEF);

        // Out-of-range reads
        read_chk("rd_oor_400", 16'h0400, 16'h0000);
        read_chk("rd_oor_410", 16'h0410, 16'h0000);
        read_chk("rd_after_oor", 16'h0010, 16'h1234);

        // Wrap, back-to-back bytes
        fw[0] = 16'h1111; fw[1] = 16'h2222;
        d0 = n_done; s0 = n_stall;
        send_frame(16'h03FF, 2, 0, 1'b0);
        check("wrap_stall_cnt", 16'(n_stall - s0), 16'd2);
        check("wrap_done_cnt", 16'(n_done - d0), 16'd1);
        read_chk("wrap_rd_3ff", 16'h03FF, 16'h1111);
        read_chk("wrap_rd_000", 16'h0000, 16'h2222);

        // Wrap with 5-cycle gaps between bytes
        fw[0] = 16'hAAAA; fw[1] = 16'h5555;
        d0 = n_done; s0 = n_stall;
        send_frame(16'h03FF, 2, 5, 1'b0);
        check("gap_stall_cnt", 16'(n_stall - s0), 16'd2);
        check("gap_done_cnt", 16'(n_done - d0), 16'd1);
        read_chk("gap_rd_3ff", 16'h03FF, 16'hAAAA);
        read_chk("gap_rd_000", 16'h0000, 16'h5555);

        // COUNT = 0 writes 256 words; the word just past the block is untouched
        fw[0] = 16'h7777;
        send_frame(16'h0200, 1, 0, 1'b0);
        for (int i = 0; i < 256; i++) fw[i] = 16'hC3C3 ^ 16'(i);
        d0 = n_done; s0 = n_stall;
        send_frame(16'h0100, 256, 0, 1'b0);
        check("c256_stall_cnt", 16'(n_stall - s0), 16'd256);
        check("c256_done_cnt", 16'(n_done - d0), 16'd1);
        read_chk("c256_rd_100", 16'h0100, 16'hC3C3);
        read_chk("c256_rd_1ff", 16'h01FF, 16'hC33C);
        read_chk("c256_rd_200", 16'h0200, 16'h7777);

        // Reset after the first data low byte of a frame targeting 0x040
        send_byte(8'hA5, 0);
        send_byte(8'h40, 0);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h34, 0);
        RST = 1'b1;
        #1;
        check("midrst_ready", bus.ld_ready, 16'd0);
        check("midrst_busy", bus.ld_busy, 16'd0);
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        #1;
        d0 = n_done;
        send_byte(8'h34, 0);
        check("midrst_discard_busy", bus.ld_busy, 16'd0);
        send_byte(8'h12, 0);
        check("midrst_idle_busy", bus.ld_busy, 16'd0);
        check("midrst_done_cnt", 16'(n_done - d0), 16'd0);
        read_chk("midrst_rd_040", 16'h0040, 16'hBEEF);
        read_chk("midrst_rd_010", 16'h0010, 16'h1234);

`ifdef AVR_PMEM_CHKSUM_EN
        // Bad checksum: words are still written, error sticks until next header
        fw[0] = 16'hCAFE; fw[1] = 16'hF00D;
        d0 = n_done;
        send_frame(16'h0050, 2, 0, 1'b1);
        check("bad_done_cnt", 16'(n_done - d0), 16'd1);
        check("bad_err", bus.ld_err, 16'd1);
        read_chk("bad_rd_050", 16'h0050, 16'hCAFE);
        read_chk("bad_rd_051", 16'h0051, 16'hF00D);
        send_byte(8'h00, 0);
        check("bad_err_sticky", bus.ld_err, 16'd1);
        send_byte(8'hA5, 0);
        check("bad_err_clear", bus.ld_err, 16'd0);
        send_byte(8'h60, 0);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h6C, 0);
        repeat (3) begin @(posedge CLK); #1; end
        check("recover_err", bus.ld_err, 16'd0);
        read_chk("recover_rd_060", 16'h0060, 16'h2211);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
